// File: rtl/tecmo_pkg.sv
// tecmo_pkg: shared SDRAM widths and the ROM writer FSM state type
package tecmo_pkg;
  localparam int SDRAM_ADDR_WIDTH = 23;
  localparam int SDRAM_DATA_WIDTH = 32;
  typedef enum logic {IDLE, REQ} writer_state_t;
endpackage

// File: rtl/rom_sdram_writer_if.sv
// rom_sdram_writer_if: ioctl byte stream in, SDRAM req/ack write port out, plus busy/done status
interface rom_sdram_writer_if import tecmo_pkg::*; #(parameter int IOCTL_AW = 20);
  logic ioctl_download;
  logic ioctl_wr;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [7:0] ioctl_dout;
  logic ioctl_wait;
  logic [SDRAM_ADDR_WIDTH-1:0] sdram_addr;
  logic [SDRAM_DATA_WIDTH-1:0] sdram_data;
  logic sdram_we;
  logic sdram_req;
  logic sdram_ack;
  logic busy;
  logic done;
  modport master(input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sdram_ack,
                 output ioctl_wait, sdram_addr, sdram_data, sdram_we, sdram_req, busy, done);
  modport slave(output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, sdram_ack,
                input ioctl_wait, sdram_addr, sdram_data, sdram_we, sdram_req, busy, done);
endinterface

// File: rtl/word_fifo.sv
// word_fifo: synchronous FIFO; push/din in, pop in, head/count/empty/full out
module word_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign head = mem[rp];
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
endmodule

// File: rtl/rom_sdram_writer.sv
// rom_sdram_writer: packs ioctl bytes into LE 32-bit words and writes them to SDRAM via req/ack (clk, reset, bus)
module rom_sdram_writer import tecmo_pkg::*; #(
  parameter int IOCTL_AW = 20,
  parameter logic [SDRAM_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  rom_sdram_writer_if.master bus
);
  localparam int WAW = IOCTL_AW - 2;
  localparam int EW = WAW + SDRAM_DATA_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  writer_state_t state, state_nx;
  logic [31:0] asm_data, mrg_data;
  logic [3:0] asm_valid, mrg_valid;
  logic [WAW-1:0] asm_waddr, waddr;
  logic [1:0] lane;
  logic [EW-1:0] din, head;
  logic [CW-1:0] count;
  logic dl_q, dl_fall, done_arm, accept, asm_any, new_word, flush, push, pop, empty, full;
  assign lane = bus.ioctl_addr[1:0];
  assign waddr = bus.ioctl_addr[IOCTL_AW-1:2];
  assign accept = bus.ioctl_wr & bus.ioctl_download & ~bus.ioctl_wait;
  assign dl_fall = dl_q & ~bus.ioctl_download;
  assign asm_any = |asm_valid;
  // a complete word still sitting in assembly (lane 3 loaded alongside a new-word push) is closed too
  assign new_word = accept & asm_any & ((waddr != asm_waddr) | asm_valid[3]);
  assign flush = ~new_word & ((accept & (&lane)) | asm_valid[3] | (dl_fall & asm_any));
  assign push = new_word | flush;
  assign din = new_word ? {asm_waddr, asm_data} : {accept ? waddr : asm_waddr, mrg_data};
  always_comb begin
    mrg_data = new_word ? '0 : asm_data;
    mrg_valid = new_word ? '0 : asm_valid;
    if (accept) begin
      mrg_data[8*lane +: 8] = bus.ioctl_dout;
      mrg_valid[lane] = 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (empty ? IDLE : REQ) : (bus.sdram_ack ? IDLE : REQ);
  end
  assign pop = (state == REQ) & bus.sdram_ack;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dl_q <= 1'b0;
      done_arm <= 1'b0;
      asm_data <= '0;
      asm_valid <= '0;
      asm_waddr <= '0;
    end else begin
      state <= state_nx;
      dl_q <= bus.ioctl_download;
      done_arm <= (done_arm & ~bus.done) | dl_fall;
      asm_data <= flush ? '0 : mrg_data;
      asm_valid <= flush ? '0 : mrg_valid;
      asm_waddr <= accept ? waddr : asm_waddr;
    end
  end
  word_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .head(head), .count(count), .empty(empty), .full(full)
  );
  // holding one slot back leaves room for a new-word or flush push after the stall
  assign bus.ioctl_wait = full | (count == CW'(DEPTH - 1));
  assign bus.sdram_req = state == REQ;
  assign bus.sdram_we = bus.sdram_req;
  assign bus.sdram_addr = bus.sdram_req ? BASE_ADDR + SDRAM_ADDR_WIDTH'(head[EW-1:SDRAM_DATA_WIDTH]) : '0;
  assign bus.sdram_data = bus.sdram_req ? head[SDRAM_DATA_WIDTH-1:0] : '0;
  assign bus.busy = ~empty | asm_any | (state == REQ);
  assign bus.done = done_arm & ~bus.ioctl_download & empty & ~asm_any & (state == IDLE);
endmodule
